// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that hands whole messages from N_REQ requester buffers to
// the single UART transmit message input, one 16-bit word at a time under BUSY.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [8*N_REQ-1:0]    i_req_len,
    input  logic [N_REQ-1:0]      i_req_par,
    input  logic [16*N_REQ-1:0]   i_req_data,
    output logic [N_REQ-1:0]      o_gnt,
    output logic [N_REQ-1:0]      o_rd,
    output logic [N_REQ-1:0]      o_ack,
    output logic [15:0]           o_data,
    output logic                  o_ena,
    output logic [7:0]            o_msg_len_in,
    output logic                  o_parity_in,
    input  logic                  i_busy,
    output logic                  o_active
);
    localparam int unsigned IdxW = $clog2(N_REQ);

    typedef enum logic [2:0] {StIdle, StLatch, StFetch, StWait, StSend, StDone} state_e;

    state_e           r_state, w_state_nxt;
    logic [IdxW-1:0]  r_ptr, w_ptr_nxt;
    logic [IdxW-1:0]  r_sel, w_sel_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0] r_rd, w_rd_nxt;
    logic [N_REQ-1:0] r_ack, w_ack_nxt;
    logic [15:0]      r_data, w_data_nxt;
    logic             r_ena, w_ena_nxt;
    logic [7:0]       r_len, w_len_nxt;
    logic             r_par, w_par_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic [1:0]       r_wait, w_wait_nxt;

    logic [IdxW-1:0]  w_cand;
    logic [IdxW-1:0]  w_arb_idx;
    logic             w_arb_found;
    logic [N_REQ-1:0] w_sel_oh;
    logic [7:0]       w_sel_len;
    logic [15:0]      w_sel_data;

    // Scan farthest-first so the requester right after r_ptr overrides all others.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_cand      = '0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            w_cand = IdxW'((int'(r_ptr) + k) % int'(N_REQ));
            if (i_req[w_cand]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_oh        = '0;
        w_sel_oh[r_sel] = 1'b1;
    end

    assign w_sel_len  = i_req_len[{r_sel, 3'b000} +: 8];
    assign w_sel_data = i_req_data[{r_sel, 4'b0000} +: 16];

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_rd_nxt    = '0;
        w_ack_nxt   = '0;
        w_data_nxt  = r_data;
        w_ena_nxt   = r_ena;
        w_len_nxt   = r_len;
        w_par_nxt   = r_par;
        w_cnt_nxt   = r_cnt;
        w_wait_nxt  = r_wait;
        unique case (r_state)
            StIdle: begin
                if (w_arb_found) begin
                    w_sel_nxt   = w_arb_idx;
                    w_state_nxt = StLatch;
                end
            end
            StLatch: begin
                w_gnt_nxt = w_sel_oh;
                w_len_nxt = w_sel_len;
                w_cnt_nxt = w_sel_len;
                w_par_nxt = i_req_par[r_sel];
                if (w_sel_len == 8'd0) begin
                    w_ack_nxt   = w_sel_oh;
                    w_state_nxt = StDone;
                end else begin
                    w_state_nxt = StFetch;
                end
            end
            StFetch: begin
                w_rd_nxt    = w_sel_oh;
                w_wait_nxt  = '0;
                w_state_nxt = StWait;
            end
            StWait: begin
                if (r_wait == 2'(RD_LAT - 1)) begin
                    w_data_nxt  = w_sel_data;
                    w_ena_nxt   = 1'b1;
                    w_state_nxt = StSend;
                end else begin
                    w_wait_nxt = r_wait + 2'd1;
                end
            end
            StSend: begin
                if (!i_busy) begin
                    w_ena_nxt = 1'b0;
                    w_cnt_nxt = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        w_ack_nxt   = w_sel_oh;
                        w_state_nxt = StDone;
                    end else begin
                        w_state_nxt = StFetch;
                    end
                end
            end
            StDone: begin
                w_gnt_nxt   = '0;
                w_ptr_nxt   = r_sel;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_ptr   <= IdxW'(N_REQ - 1);
            r_sel   <= '0;
            r_gnt   <= '0;
            r_rd    <= '0;
            r_ack   <= '0;
            r_data  <= '0;
            r_ena   <= 1'b0;
            r_len   <= '0;
            r_par   <= 1'b0;
            r_cnt   <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_rd    <= w_rd_nxt;
            r_ack   <= w_ack_nxt;
            r_data  <= w_data_nxt;
            r_ena   <= w_ena_nxt;
            r_len   <= w_len_nxt;
            r_par   <= w_par_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    assign o_gnt        = r_gnt;
    assign o_rd         = r_rd;
    assign o_ack        = r_ack;
    assign o_data       = r_data;
    assign o_ena        = r_ena;
    assign o_msg_len_in = r_len;
    assign o_parity_in  = r_par;
    assign o_active     = |r_gnt;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmit message path among up to N_REQ independent message sources. It sits between the requester-side message buffers and the message input of the UART process block (DATA/ENA/MSG_LEN_IN/PARITY_IN/BUSY). It grants one whole message at a time, fetches its 16-bit words from the granted requester, and hands them to the transmitter under the BUSY back-pressure. Messages are never interleaved.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- RD_LAT, 1, read latency of requester buffers in cycles (1 or 2)

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; one clock, reset is asynchronous and active-low
- REQ  in  N_REQ  requester i has a complete message ready; level
- REQ_LEN  in  8*N_REQ  message length in 16-bit words, slice i = [8i+7:8i]
- REQ_PAR  in  N_REQ  parity flag of requester i's message
- REQ_DATA  in  16*N_REQ  read data from requester i's buffer, valid RD_LAT cycles after RD[i]
- GNT  out  N_REQ  one-hot grant, held for the whole message
- RD  out  N_REQ  one-cycle word read strobe to requester i
- ACK  out  N_REQ  one-cycle pulse: requester i's message fully handed over
- DATA  out  16  word to transmitter
- ENA  out  1  word valid to transmitter
- MSG_LEN_IN  out  8  latched length of current message, stable while GNT!=0
- PARITY_IN  out  1  latched parity of current message, stable while GNT!=0
- BUSY  in  1  transmitter cannot accept a word
- ACTIVE  out  1  a message is in progress (GNT!=0)

## Operation
- States: IDLE, LATCH, FETCH, WAIT, SEND, DONE.
- IDLE: if REQ!=0, choose first set REQ bit starting at index ptr+1 (mod N_REQ), wrapping; go LATCH. Otherwise stay.
- LATCH: set GNT[sel]; latch REQ_LEN slice into MSG_LEN_IN and remaining-word counter cnt, latch REQ_PAR into PARITY_IN. If length==0 go DONE, else FETCH.
- FETCH: pulse RD[sel] one cycle; go WAIT.
- WAIT: count RD_LAT cycles; on last, register REQ_DATA slice into DATA, assert ENA; go SEND.
- SEND: ENA held high with DATA stable until a cycle with ENA=1 and BUSY=0 (word transferred). On that cycle drop ENA, cnt<=cnt-1; if cnt was 1 go DONE, else FETCH.
- DONE: pulse ACK[sel], ptr<=sel, clear GNT, MSG_LEN_IN, PARITY_IN hold last value; go IDLE.
- REQ deassertion while granted is ignored; message always completes with exactly MSG_LEN_IN words.
- REQ changes of non-granted requesters never affect the current message.
- Requester must lower REQ within 1 cycle after ACK or it is re-arbitrated (fairness still holds via ptr).
- cnt is 8-bit unsigned; length 255 is the maximum; 0 means empty message (ACK only, no ENA, no RD).

## Timing
- Reset (RST low, async): state IDLE, ptr=N_REQ-1 (so index 0 wins first), GNT=0, RD=0, ACK=0, ENA=0, DATA=0, MSG_LEN_IN=0, PARITY_IN=0, ACTIVE=0, cnt=0.
- Reset mid-message: everything returns to reset values immediately; partially sent message is abandoned, no ACK.
- REQ sampled in IDLE at edge k -> GNT at k+1, first RD at k+2, ENA at k+3+RD_LAT-1.
- Per word with BUSY=0: 2+RD_LAT cycles (FETCH, WAIT x RD_LAT, SEND).
- ACK asserted one cycle after final transfer; next IDLE arbitration the cycle after ACK; min gap between messages 2 cycles.
- ENA never asserted while GNT=0; at most one RD bit and one GNT bit high; RD only when GNT of same index set.
- BUSY high when ENA rises: ENA and DATA hold indefinitely (no timeout).

## Test plan
- Single requester 0, REQ_LEN=3, PAR=1, words 0x1111/0x2222/0x3333, BUSY=0 -> GNT=0001, three RD pulses, DATA sequence in order, MSG_LEN_IN=3, PARITY_IN=1, one ACK[0] after third transfer.
- All four REQ high continuously, each len 2 -> grant order 0,1,2,3,0 and each ACK after exactly 2 transfers, no interleaving.
- BUSY held high 50 cycles during second word -> ENA and DATA stable for 50 cycles, transfer on first BUSY=0 cycle, no extra RD.
- REQ_LEN=0 on requester 2 -> GNT[2] one phase, ACK[2], zero RD and zero ENA.
- REQ[1] dropped mid-message (len 4) -> all 4 words still sent, ACK[1] pulses.
- RST low during word 2 of len 5 -> all outputs 0 at once, no ACK; after release REQ[0] served first.
